writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Writeback stage of the RISC-V datapath and sole driver of the register file write port (write enable, destination index, write data).
- Accepts one completed instruction at a time from MEM: an ALU result, a link value (PC+4) or a load.
- Load data arriving from data memory is aligned and sign/zero-extended before the write.
- Keeps a pending-write scoreboard so decode can stall reads of registers not yet written back.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- MEM_TIMEOUT, 15, maximum cycles spent in WAIT_MEM before a load is abandoned; range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  MEM stage presents an instruction
- in_ready  output  1  unit can accept; equals (state==IDLE)
- in_rd  input  5  destination register index
- in_sel  input  2  00 ALU, 01 load, 10 link, 11 reserved
- in_alu  input  32  ALU result
- in_pc4  input  32  link value
- in_funct3  input  3  load type (valid when in_sel=01)
- in_addr_lo  input  2  load address bits [1:0]
- mem_rvalid  input  1  load data valid, single-cycle pulse
- mem_rdata  input  32  raw aligned word from data memory
- issue_valid  input  1  decode issues an instruction that will write issue_rd
- issue_rd  input  5  destination of the issued instruction
- reg_write  output  1  register file write enable
- rs_write  output  5  register file write index
- data_write  output  32  register file write data
- pending  output  32  bit i set while a write to xi is outstanding; bit 0 always 0
- err  output  3  sticky flags: [0] misaligned load, [1] bad funct3 or bad sel, [2] timeout or spurious mem_rvalid

Behaviour:
- Reset:
  - state = IDLE; timeout counter = 0.
  - reg_write, rs_write, data_write, pending and err are all 0.
  - A reset in any state, including WAIT_MEM, abandons the in-flight load with no write; a later mem_rvalid in IDLE then sets err[2].
- States: IDLE, WAIT_MEM.
- Handshake: an instruction is accepted when in_valid && in_ready at a rising edge.
- ALU or link accepted at edge N:
  - reg_write=1 during cycle N+1 with rs_write=in_rd and data_write=in_alu or in_pc4.
  - State stays IDLE, giving throughput of one per cycle.
- Load accepted at edge N:
  - Go to WAIT_MEM and latch rd, funct3, addr_lo; counter = 0.
  - At the edge where mem_rvalid=1, the extended data is registered: reg_write=1 in the following cycle, state returns to IDLE, in_ready=1 in that cycle.
  - The counter increments on each WAIT_MEM edge without mem_rvalid. On reaching MEM_TIMEOUT, return to IDLE with no write and set err[2].
- Extension by funct3:
  - 000 LB: byte selected by addr_lo, sign-extended.
  - 100 LBU: byte selected by addr_lo, zero-extended.
  - 001 LH: halfword selected by addr_lo[1], sign-extended.
  - 101 LHU: halfword selected by addr_lo[1], zero-extended.
  - 010 LW: full word.
- Load errors:
  - Misaligned (LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0): still wait for mem_rvalid, suppress the write, set err[0].
  - funct3 011, 110 or 111: suppress the write, set err[1].
  - in_sel=11: accepted, no write, set err[1].
- x0 handling: rd=0 never asserts reg_write. The instruction still completes normally.
- reg_write is high for exactly one cycle per write. rs_write and data_write hold their last value otherwise.
- mem_rvalid while in IDLE is ignored and sets err[2].
- Scoreboard:
  - issue_valid with issue_rd!=0 sets pending[issue_rd].
  - Registering a write for rd clears pending[rd] on the same edge that raises reg_write.
  - Suppressed writes (error, timeout) also clear pending[rd].
  - Set and clear of the same index on the same edge: set wins.
  - pending updates combinationally neither way; it is a registered output.
- err bits are cleared only by reset.

Test Plan:
- Back-to-back ALU ops x5=0x11, x6=0x22, x7=0x33, in_valid held 3 cycles -> reg_write high 3 consecutive cycles, data 0x11/0x22/0x33, in_ready stays 1.
- LB x8, addr_lo=3, mem_rdata=0x80FF_FF7F, mem_rvalid 4 cycles after accept -> in_ready=0 while waiting; one write x8=0xFFFF_FF80. Repeat with LBU -> 0x0000_0080.
- LH addr_lo=1 -> err[0]=1, no reg_write, pending[rd] cleared. LW addr_lo=0, rdata=0xDEAD_BEEF, rd=0 -> no reg_write, err stays 0.
- Load with no mem_rvalid -> after 15 cycles in WAIT_MEM, return to IDLE, err[2]=1, no write. Stray mem_rvalid in IDLE -> err[2]=1.
- issue_valid rd=9, then ALU write to x9 in the same cycle as a new issue of rd=9 -> pending[9] remains 1; the later write clears it; issue_rd=0 -> pending[0] stays 0.
- Assert reset during WAIT_MEM -> next cycle all outputs 0, state IDLE; a mem_rvalid following reset produces no write and sets err[2].

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit: RISC-V writeback stage (ALU/link/load writes, load extension, pending-write scoreboard); ports: clk, reset, in_* from MEM, mem_* load data, issue_* from decode, reg_write/rs_write/data_write to regfile, pending, err
module writeback_unit #(
  parameter int XLEN = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      in_sel,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            reg_write,
  output logic [4:0]      rs_write,
  output logic [XLEN-1:0] data_write,
  output logic [XLEN-1:0] pending,
  output logic [2:0]      err
);
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  state_t r_state, w_state;
  logic [7:0] r_cnt, w_cnt;
  logic [4:0] r_rd, r_wrd, w_wrd, w_clr_rd;
  logic [2:0] r_f3, r_err, w_err;
  logic [1:0] r_lo;
  logic r_we, w_we, w_clr, w_mis, w_bad;
  logic [XLEN-1:0] r_wd, w_wd, w_ext, r_pend, w_set, w_clrm;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  assign in_ready = r_state == IDLE;
  assign w_byte = mem_rdata[{r_lo, 3'b000} +: 8];
  assign w_half = r_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign w_mis = (r_f3[1:0] == 2'b01 && r_lo[0]) || (r_f3 == 3'b010 && r_lo != 2'b00);
  assign w_bad = r_f3 == 3'b011 || r_f3[2:1] == 2'b11;
  assign w_ext = r_f3 == 3'b000 ? {{24{w_byte[7]}}, w_byte} :
                 r_f3 == 3'b100 ? {24'b0, w_byte} :
                 r_f3 == 3'b001 ? {{16{w_half[15]}}, w_half} :
                 r_f3 == 3'b101 ? {16'b0, w_half} : mem_rdata;
  // A suppressed completion still clears its scoreboard bit; a same-edge issue wins.
  assign w_set = (issue_valid && issue_rd != 5'd0) ? XLEN'(1) << issue_rd : '0;
  assign w_clrm = w_clr ? XLEN'(1) << w_clr_rd : '0;
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_we = 1'b0;
    w_wd = r_wd;
    w_wrd = r_wrd;
    w_clr = 1'b0;
    w_clr_rd = r_rd;
    w_err = r_err;
    if (r_state == IDLE) begin
      if (mem_rvalid) w_err[2] = 1'b1;
      if (in_valid && in_sel == 2'b01) begin
        w_state = WAIT_MEM;
        w_cnt = 8'd0;
      end else if (in_valid) begin
        w_clr = 1'b1;
        w_clr_rd = in_rd;
        w_wrd = in_rd;
        w_wd = in_sel[1] ? in_pc4 : in_alu;
        w_we = in_sel != 2'b11 && in_rd != 5'd0;
        if (in_sel == 2'b11) w_err[1] = 1'b1;
      end
    end else if (mem_rvalid) begin
      w_state = IDLE;
      w_clr = 1'b1;
      w_wrd = r_rd;
      w_wd = w_ext;
      w_we = !w_mis && !w_bad && r_rd != 5'd0;
      w_err[0] = r_err[0] | w_mis;
      w_err[1] = r_err[1] | w_bad;
    end else if (r_cnt == 8'(MEM_TIMEOUT - 1)) begin
      w_state = IDLE;
      w_clr = 1'b1;
      w_err[2] = 1'b1;
    end else begin
      w_cnt = r_cnt + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_rd <= '0;
      r_f3 <= '0;
      r_lo <= '0;
      r_we <= 1'b0;
      r_wrd <= '0;
      r_wd <= '0;
      r_pend <= '0;
      r_err <= '0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_we <= w_we;
      r_err <= w_err;
      r_pend <= (r_pend & ~w_clrm) | w_set;
      if (in_valid && in_ready) begin
        r_rd <= in_rd;
        r_f3 <= in_funct3;
        r_lo <= in_addr_lo;
      end
      if (w_we) begin
        r_wrd <= w_wrd;
        r_wd <= w_wd;
      end
    end
  end
  assign reg_write = r_we;
  assign rs_write = r_wrd;
  assign data_write = r_wd;
  assign pending = r_pend;
  assign err = r_err;
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed self-checking bench for writeback_unit
module tb_writeback_unit;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, mem_rvalid = 1'b0, issue_valid = 1'b0;
  logic [4:0] in_rd = '0, issue_rd = '0;
  logic [1:0] in_sel = '0, in_addr_lo = '0;
  logic [31:0] in_alu = '0, in_pc4 = '0, mem_rdata = '0;
  logic [2:0] in_funct3 = '0;
  logic in_ready, reg_write;
  logic [4:0] rs_write;
  logic [31:0] data_write, pending;
  logic [2:0] err;
  int n_chk = 0, n_fail = 0;
  writeback_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_sel(in_sel), .in_alu(in_alu), .in_pc4(in_pc4), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .reg_write(reg_write),
    .rs_write(rs_write), .data_write(data_write), .pending(pending), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic rst();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic alu(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] v);
    in_valid = 1'b1; in_sel = sel; in_rd = rd; in_alu = v; in_pc4 = v;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    in_valid = 1'b1; in_sel = 2'b01; in_rd = rd; in_funct3 = f3; in_addr_lo = lo;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic rv(input logic [31:0] d);
    mem_rvalid = 1'b1; mem_rdata = d;
    tick();
    mem_rvalid = 1'b0;
  endtask
  initial begin
    tick(2);
    chk("rst_we", reg_write, 0); chk("rst_rd", rs_write, 0); chk("rst_wd", data_write, 0);
    chk("rst_pend", pending, 0); chk("rst_err", err, 0); chk("rst_ready", in_ready, 1);
    reset = 1'b0;
    in_valid = 1'b1; in_sel = 2'b00;
    in_rd = 5'd5; in_alu = 32'h11; tick();
    chk("b2b1_we", reg_write, 1); chk("b2b1_rd", rs_write, 5); chk("b2b1_wd", data_write, 32'h11); chk("b2b1_rdy", in_ready, 1);
    in_rd = 5'd6; in_alu = 32'h22; tick();
    chk("b2b2_we", reg_write, 1); chk("b2b2_rd", rs_write, 6); chk("b2b2_wd", data_write, 32'h22);
    in_rd = 5'd7; in_alu = 32'h33; tick();
    chk("b2b3_we", reg_write, 1); chk("b2b3_rd", rs_write, 7); chk("b2b3_wd", data_write, 32'h33);
    in_valid = 1'b0; tick();
    chk("b2b_end_we", reg_write, 0); chk("b2b_hold_wd", data_write, 32'h33);
    alu(5'd1, 2'b10, 32'h104);
    chk("link_we", reg_write, 1); chk("link_wd", data_write, 32'h104);
    load(5'd8, 3'b000, 2'd3);
    chk("lb_wait_rdy", in_ready, 0);
    tick(3);
    chk("lb_wait_we", reg_write, 0); chk("lb_wait_rdy2", in_ready, 0);
    rv(32'h80FF_FF7F);
    chk("lb_we", reg_write, 1); chk("lb_rd", rs_write, 8); chk("lb_wd", data_write, 32'hFFFF_FF80); chk("lb_rdy", in_ready, 1);
    tick();
    chk("lb_once", reg_write, 0);
    load(5'd8, 3'b100, 2'd3); tick(3); rv(32'h80FF_FF7F);
    chk("lbu_wd", data_write, 32'h0000_0080);
    load(5'd3, 3'b001, 2'd2); rv(32'h80FF_FF7F);
    chk("lh_wd", data_write, 32'hFFFF_80FF);
    load(5'd3, 3'b101, 2'd0); rv(32'h80FF_FF7F);
    chk("lhu_wd", data_write, 32'h0000_FF7F);
    load(5'd11, 3'b010, 2'd0); rv(32'hDEAD_BEEF);
    chk("lw_we", reg_write, 1); chk("lw_rd", rs_write, 11); chk("lw_wd", data_write, 32'hDEAD_BEEF);
    issue_valid = 1'b1; issue_rd = 5'd10;
    load(5'd10, 3'b001, 2'd1);
    issue_valid = 1'b0;
    chk("mis_pend_set", pending, 32'h400);
    rv(32'h1234_5678);
    chk("mis_we", reg_write, 0); chk("mis_err", err, 3'b001); chk("mis_pend_clr", pending, 0);
    rst();
    alu(5'd14, 2'b11, 32'h5);
    chk("sel11_we", reg_write, 0); chk("sel11_err", err, 3'b010);
    rst();
    load(5'd13, 3'b011, 2'd0); rv(32'h5);
    chk("badf3_we", reg_write, 0); chk("badf3_err", err, 3'b010);
    rst();
    load(5'd0, 3'b010, 2'd0); rv(32'hDEAD_BEEF);
    chk("x0_we", reg_write, 0); chk("x0_err", err, 0); chk("x0_rdy", in_ready, 1);
    rst();
    issue_valid = 1'b1; issue_rd = 5'd12;
    load(5'd12, 3'b010, 2'd0);
    issue_valid = 1'b0;
    chk("to_pend", pending, 32'h1000);
    tick(14);
    chk("to_still_wait", in_ready, 0); chk("to_no_err_yet", err, 0);
    tick();
    chk("to_rdy", in_ready, 1); chk("to_err", err, 3'b100); chk("to_we", reg_write, 0); chk("to_pend_clr", pending, 0);
    rst();
    mem_rvalid = 1'b1; tick(); mem_rvalid = 1'b0;
    chk("stray_err", err, 3'b100); chk("stray_we", reg_write, 0);
    rst();
    issue_valid = 1'b1; issue_rd = 5'd9; tick();
    chk("sb_set", pending, 32'h200);
    alu(5'd9, 2'b00, 32'h99);
    chk("sb_we", reg_write, 1); chk("sb_setwins", pending, 32'h200);
    issue_valid = 1'b0;
    alu(5'd9, 2'b00, 32'h9A);
    chk("sb_clr", pending, 0); chk("sb_wd", data_write, 32'h9A);
    issue_valid = 1'b1; issue_rd = 5'd0; tick(); issue_valid = 1'b0;
    chk("sb_x0", pending, 0);
    issue_valid = 1'b1; issue_rd = 5'd15;
    load(5'd15, 3'b010, 2'd0);
    issue_valid = 1'b0;
    tick();
    rst();
    chk("rw_we", reg_write, 0); chk("rw_rd", rs_write, 0); chk("rw_wd", data_write, 0);
    chk("rw_pend", pending, 0); chk("rw_err", err, 0); chk("rw_rdy", in_ready, 1);
    rv(32'hCAFE_F00D);
    chk("rw_rv_we", reg_write, 0); chk("rw_rv_err", err, 3'b100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
